// File: rtl/module_counter_tick.sv
// Free-running modulo-(max_count+1) tick generator with a one-cycle terminal-count pulse.
// Define MODULE_COUNTER_WRAPS_EN to add a saturating 'wraps' count of tc events since reset.
module module_counter_tick #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] max_count,
    output logic             tc,
`ifdef MODULE_COUNTER_WRAPS_EN
    output logic [WIDTH-1:0] wraps,
`endif
    output logic [WIDTH-1:0] count
);

    logic at_terminal;

    // Using >= rather than == makes a run-time lowering of max_count wrap on the next
    // enabled cycle instead of running all the way round through 2^WIDTH.
    assign at_terminal = (count >= max_count);
    assign tc          = !rst && enable && at_terminal;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (enable) begin
            if (at_terminal) begin
                count <= '0;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

`ifdef MODULE_COUNTER_WRAPS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wraps <= '0;
        end else if (tc && (wraps != '1)) begin
            wraps <= wraps + WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_module_counter_tick.sv
// Self-checking bench for module_counter_tick: directed period scenarios with closed-form
// expectations plus a randomized run against a period-position reference model.
module tb_module_counter_tick;

    localparam int WIDTH = 8;
    localparam int ALL_ONES = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [WIDTH-1:0] max_count;
    logic             tc;
    logic [WIDTH-1:0] count;
`ifdef MODULE_COUNTER_WRAPS_EN
    logic [WIDTH-1:0] wraps;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    module_counter_tick #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .max_count (max_count),
        .tc        (tc),
`ifdef MODULE_COUNTER_WRAPS_EN
        .wraps     (wraps),
`endif
        .count     (count)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One reset cycle, then the first cycle after release is "cycle 1" with count 0.
    task automatic restart(input int mc);
        rst       = 1'b1;
        enable    = 1'b1;
        max_count = WIDTH'(mc);
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        enable    = 1'b1;
        max_count = '0;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_compared++;
            if (tc !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_tc: got %0b expected 0", tc);
            end
            n_compared++;
            if (count !== '0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_count: got %0d expected 0", count);
            end
            next_cycle();
        end
    endtask

    // Enable held high: tc exactly on cycles that are multiples of mc+1, count = (k-1) mod (mc+1).
    task automatic test_period(input int mc, input int cycles);
        int exp_count;
        bit exp_tc;
        restart(mc);
        for (int k = 1; k <= cycles; k++) begin
            exp_count = (k - 1) % (mc + 1);
            exp_tc    = (k % (mc + 1)) == 0;
            @(negedge clk);
            n_compared++;
            if (count !== WIDTH'(exp_count)) begin
                n_mismatched++;
                $display("[TB] FAIL period%0d_count cycle %0d: got %0d expected %0d", mc, k, count, exp_count);
            end
            n_compared++;
            if (tc !== exp_tc) begin
                n_mismatched++;
                $display("[TB] FAIL period%0d_tc cycle %0d: got %0b expected %0b", mc, k, tc, exp_tc);
            end
            next_cycle();
        end
    endtask

    task automatic test_max_zero();
        rst       = 1'b1;
        enable    = 1'b1;
        max_count = '0;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) rst = 1'b0;
            @(negedge clk);
            n_compared++;
            if (tc !== (k >= 2)) begin
                n_mismatched++;
                $display("[TB] FAIL max0_tc cycle %0d: got %0b expected %0b", k, tc, (k >= 2));
            end
            if (k >= 1) begin
                n_compared++;
                if (count !== '0) begin
                    n_mismatched++;
                    $display("[TB] FAIL max0_count cycle %0d: got %0d expected 0", k, count);
                end
            end
            next_cycle();
        end
    endtask

    // Enable alternates 1/0 starting high; only odd cycles advance, so the period is 22 clocks.
    task automatic test_enable_toggle();
        int exp_count;
        int tc_hits;
        bit exp_tc;
        tc_hits = 0;
        restart(10);
        for (int k = 1; k <= 66; k++) begin
            enable    = (k % 2) == 1;
            exp_count = (k / 2) % 11;
            exp_tc    = enable && (exp_count == 10);
            @(negedge clk);
            if (tc === 1'b1) tc_hits++;
            n_compared++;
            if (count !== WIDTH'(exp_count)) begin
                n_mismatched++;
                $display("[TB] FAIL toggle_count cycle %0d: got %0d expected %0d", k, count, exp_count);
            end
            n_compared++;
            if (tc !== exp_tc) begin
                n_mismatched++;
                $display("[TB] FAIL toggle_tc cycle %0d: got %0b expected %0b", k, tc, exp_tc);
            end
            next_cycle();
        end
        n_compared++;
        if (tc_hits != 3) begin
            n_mismatched++;
            $display("[TB] FAIL toggle_tc_hits: got %0d expected 3", tc_hits);
        end
        enable = 1'b1;
    endtask

    task automatic test_lower_max();
        restart(200);
        for (int k = 1; k <= 150; k++) next_cycle();
        max_count = WIDTH'(100);
        @(negedge clk);
        n_compared++;
        if (count !== WIDTH'(150)) begin
            n_mismatched++;
            $display("[TB] FAIL lower_count: got %0d expected 150", count);
        end
        n_compared++;
        if (tc !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL lower_tc: got %0b expected 1", tc);
        end
        next_cycle();
        for (int k = 1; k <= 202; k++) begin
            @(negedge clk);
            n_compared++;
            if (count !== WIDTH'((k - 1) % 101)) begin
                n_mismatched++;
                $display("[TB] FAIL lower_wrap_count cycle %0d: got %0d expected %0d", k, count, (k - 1) % 101);
            end
            n_compared++;
            if (tc !== ((k % 101) == 0)) begin
                n_mismatched++;
                $display("[TB] FAIL lower_wrap_tc cycle %0d: got %0b expected %0b", k, tc, ((k % 101) == 0));
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        restart(127);
        for (int k = 1; k <= 50; k++) next_cycle();
        @(negedge clk);
        n_compared++;
        if (count !== WIDTH'(50)) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_pre_count: got %0d expected 50", count);
        end
        rst = 1'b1;
        #1;
        n_compared++;
        if (tc !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_tc: got %0b expected 0", tc);
        end
        next_cycle();
        rst = 1'b0;
        for (int k = 1; k <= 384; k++) begin
            @(negedge clk);
            n_compared++;
            if (count !== WIDTH'((k - 1) % 128)) begin
                n_mismatched++;
                $display("[TB] FAIL midreset_count cycle %0d: got %0d expected %0d", k, count, (k - 1) % 128);
            end
            n_compared++;
            if (tc !== ((k % 128) == 0)) begin
                n_mismatched++;
                $display("[TB] FAIL midreset_period_tc cycle %0d: got %0b expected %0b", k, tc, ((k % 128) == 0));
            end
`ifdef MODULE_COUNTER_WRAPS_EN
            if (k == 1) begin
                n_compared++;
                if (wraps !== '0) begin
                    n_mismatched++;
                    $display("[TB] FAIL midreset_wraps_clear: got %0d expected 0", wraps);
                end
            end
`endif
            next_cycle();
        end
`ifdef MODULE_COUNTER_WRAPS_EN
        @(negedge clk);
        n_compared++;
        if (wraps !== WIDTH'(3)) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_wraps_three: got %0d expected 3", wraps);
        end
`endif
    endtask

`ifdef MODULE_COUNTER_WRAPS_EN
    task automatic test_wraps_saturate();
        restart(0);
        for (int k = 1; k <= 300; k++) next_cycle();
        @(negedge clk);
        n_compared++;
        if (wraps !== WIDTH'(ALL_ONES)) begin
            n_mismatched++;
            $display("[TB] FAIL wraps_saturate: got %0d expected %0d", wraps, ALL_ONES);
        end
    endtask
`endif

    // Reference: 'pos' is how many enabled cycles into the current period we are. A period
    // ends on the enabled cycle where pos has reached or passed the terminal value.
    task automatic test_random();
        int pos;
        int tc_events;
        bit exp_tc;
        rst       = 1'b1;
        enable    = 1'b1;
        max_count = WIDTH'(5);
        next_cycle();
        pos       = 0;
        tc_events = 0;
        for (int k = 0; k < 1500; k++) begin
            rst    = ($urandom_range(0, 39) == 0);
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 3))
                    0:       max_count = '0;
                    1:       max_count = WIDTH'(ALL_ONES);
                    2:       max_count = WIDTH'($urandom_range(0, ALL_ONES));
                    default: max_count = WIDTH'($urandom_range(1, 12));
                endcase
            end
            exp_tc = !rst && enable && (pos >= int'(max_count));
            @(negedge clk);
            n_compared++;
            if (tc !== exp_tc) begin
                n_mismatched++;
                $display("[TB] FAIL random_tc step %0d: got %0b expected %0b", k, tc, exp_tc);
            end
            n_compared++;
            if (count !== WIDTH'(pos)) begin
                n_mismatched++;
                $display("[TB] FAIL random_count step %0d: got %0d expected %0d", k, count, pos);
            end
`ifdef MODULE_COUNTER_WRAPS_EN
            n_compared++;
            if (wraps !== WIDTH'(tc_events)) begin
                n_mismatched++;
                $display("[TB] FAIL random_wraps step %0d: got %0d expected %0d", k, wraps, tc_events);
            end
`endif
            if (rst) begin
                pos       = 0;
                tc_events = 0;
            end else if (enable) begin
                pos = exp_tc ? 0 : pos + 1;
                if (exp_tc && tc_events < ALL_ONES) tc_events++;
            end
            next_cycle();
        end
        rst    = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        $display("[TB] module_counter_tick bench starting");
        test_reset();
        test_period(1, 8);
        test_period(127, 300);
        test_period(ALL_ONES, 520);
        test_max_zero();
        test_enable_toggle();
        test_lower_max();
        test_reset_mid();
`ifdef MODULE_COUNTER_WRAPS_EN
        test_wraps_saturate();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
